// File: rtl/block_fetch_unit.sv
// block_fetch_unit: fetches a runtime-sized KxK window from up to MAX_C channel planes
// over a pipelined request/grant bus and packs the words into a flat output register.
module block_fetch_unit #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int MAX_K = 5,
  parameter int MAX_C = 4,
  parameter int MAX_OUTST = 4,
  localparam int KW = $clog2(MAX_K + 1),
  localparam int CW = $clog2(MAX_C + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [KW-1:0] size,
  input  logic [CW-1:0] channels,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_stride,
  input  logic [AW-1:0] plane_stride,
  output logic mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic mem_gnt,
  input  logic mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic busy,
  output logic done,
  output logic err,
  output logic [MAX_C*MAX_K*MAX_K*DW-1:0] out_data
);
  localparam int NW = MAX_C * MAX_K * MAX_K;
  localparam int IW = NW > 1 ? $clog2(NW) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;
  state_t state, stateNext;
  logic [KW-1:0] kReg, kLast, reqRow, reqCol, rspRow, rspCol;
  logic [CW-1:0] cReg, reqCh, rspCh;
  logic [AW-1:0] rowStride, planeStride, planeAddr, rowAddr;
  logic [OW-1:0] outst;
  logic [IW-1:0] idx;
  logic errPend, cfgBad, grant, rsp, lastReq;
  logic [DW-1:0] words [NW];

  assign cfgBad = size == '0 || size > KW'(MAX_K) || channels == '0 || channels > CW'(MAX_C);
  assign kLast = kReg - KW'(1);
  assign lastReq = reqCh == cReg - CW'(1) && reqRow == kLast && reqCol == kLast;
  assign mem_req = state == REQ && outst < OW'(MAX_OUTST);
  // Address is built from running plane/row pointers, so no multipliers are needed.
  assign mem_addr = rowAddr + AW'(reqCol);
  assign grant = mem_req && mem_gnt;
  assign rsp = mem_rvalid && (state == REQ || state == DRAIN) && outst != '0;
  assign idx = IW'(int'(rspCh) * MAX_K * MAX_K + int'(rspRow) * MAX_K + int'(rspCol));
  assign busy = state == REQ || state == DRAIN;
  assign done = state == FIN;
  assign err = state == FIN && errPend;

  for (genvar i = 0; i < NW; i++) begin : g_pack
    assign out_data[i*DW +: DW] = words[i];
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start) stateNext = cfgBad ? FIN : REQ;
      REQ: if (grant && lastReq) stateNext = DRAIN;
      DRAIN: if (outst == '0 || (outst == OW'(1) && rsp)) stateNext = FIN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      kReg <= '0;
      cReg <= '0;
      rowStride <= '0;
      planeStride <= '0;
      planeAddr <= '0;
      rowAddr <= '0;
      errPend <= 1'b0;
      reqCh <= '0;
      reqRow <= '0;
      reqCol <= '0;
      rspCh <= '0;
      rspRow <= '0;
      rspCol <= '0;
      outst <= '0;
      words <= '{default: '0};
    end else begin
      state <= stateNext;
      outst <= outst + OW'(grant) - OW'(rsp);
      if (state == IDLE && start) begin
        kReg <= size;
        cReg <= channels;
        rowStride <= row_stride;
        planeStride <= plane_stride;
        planeAddr <= base_addr;
        rowAddr <= base_addr;
        errPend <= cfgBad;
        reqCh <= '0;
        reqRow <= '0;
        reqCol <= '0;
        rspCh <= '0;
        rspRow <= '0;
        rspCol <= '0;
        words <= '{default: '0};
      end
      if (grant) begin
        if (reqCol != kLast) reqCol <= reqCol + KW'(1);
        else begin
          reqCol <= '0;
          if (reqRow != kLast) begin
            reqRow <= reqRow + KW'(1);
            rowAddr <= rowAddr + rowStride;
          end else begin
            reqRow <= '0;
            reqCh <= reqCh + CW'(1);
            planeAddr <= planeAddr + planeStride;
            rowAddr <= planeAddr + planeStride;
          end
        end
      end
      if (rsp) begin
        words[idx] <= mem_rdata;
        if (rspCol != kLast) rspCol <= rspCol + KW'(1);
        else begin
          rspCol <= '0;
          if (rspRow != kLast) rspRow <= rspRow + KW'(1);
          else begin
            rspRow <= '0;
            rspCh <= rspCh + CW'(1);
          end
        end
      end
    end
endmodule

// File: doc/block_fetch_unit.md
# block_fetch_unit

Parametrised successor to the single-channel block loader in the CNN datapath. On `start`, it fetches a runtime-sized K×K window from each of up to MAX_C channel planes in main memory. It issues pipelined read requests over a request/grant + in-order response bus, and assembles the results into a flattened output register for the convolution layer. It adds multi-channel fetch, independent row and plane strides, multiple outstanding reads, and size/channel error checking.

## Interface
- DW, 16, data word width
- AW, 16, memory address width
- MAX_K, 5, largest supported window edge
- MAX_C, 4, largest supported channel count
- MAX_OUTST, 4, maximum reads in flight (power of two, ≥1)
- KW = $clog2(MAX_K+1), CW = $clog2(MAX_C+1) (derived, not overridable)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle request to begin a fetch; ignored while busy
- size  in  KW  window edge K, sampled on accepted start
- channels  in  CW  channel count C, sampled on accepted start
- base_addr  in  AW  address of element (c=0,r=0,col=0)
- row_stride  in  AW  address step between window rows
- plane_stride  in  AW  address step between channel planes
- mem_req  out  1  read request valid
- mem_addr  out  AW  read address, stable while mem_req && !mem_gnt
- mem_gnt  in  1  request accepted this cycle when mem_req && mem_gnt
- mem_rvalid  in  1  read data valid; responses return in request order
- mem_rdata  in  DW  read data
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on rejected config
- out_data  out  MAX_C*MAX_K*MAX_K*DW  element (c,r,col) at word index c*MAX_K*MAX_K + r*MAX_K + col

## Operation
- FSM states: IDLE, REQ, DRAIN, FIN.
- IDLE: on start, latch size, channels, base_addr, row_stride, plane_stride. Clear all out_data words to 0.
  - Config is invalid if size==0, size>MAX_K, channels==0 or channels>MAX_C. Invalid config -> FIN with err pending; no requests are issued.
  - Valid config -> REQ.
- REQ: mem_req is high while the outstanding count < MAX_OUTST.
  - Request counters (c, r, col) walk col fastest, then r, then c.
  - mem_addr = base + c*plane_stride + r*row_stride + col, computed modulo 2^AW (wrap-around allowed, not flagged).
  - Counters advance only on grant. After the grant of the last element (C*K*K total) -> DRAIN.
- Response counters (c, r, col) walk in the same order and advance on each mem_rvalid. The current word is written to its out_data index.
- Outstanding counter: +1 on grant, −1 on rvalid. Both in the same cycle leaves it unchanged.
- DRAIN: wait until every response is received -> FIN. This transition can be taken in the same cycle as the last rvalid.
- FIN: done=1 (err=1 if rejected) for exactly one cycle, then -> IDLE.
- mem_rvalid in IDLE or FIN is ignored. It does not corrupt out_data.
- out_data holds its value from FIN until the next accepted start.
- Assertion of reset mid-fetch: state -> IDLE, all counters and out_data cleared, outputs at reset values. Responses from pre-reset requests are ignored only if they arrive while IDLE; the memory side must be quiesced alongside reset.

## Timing
- Reset values: mem_req=0, mem_addr=0, busy=0, done=0, err=0, out_data all zero.
- Accepted start at edge N: busy=1 and mem_req=1 from cycle N+1 (valid config).
- With mem_gnt always 1, one grant per cycle (while outstanding < MAX_OUTST). C*K*K grants occupy cycles N+1 .. N+C*K*K.
- done rises the cycle after the edge that accepts the last mem_rvalid. busy falls in the same cycle done rises.
- Minimum latency, start to done: C*K*K + L + 1 cycles, with L = memory read latency (≤ MAX_OUTST−1 for full throughput).
- Rejected config: done=err=1 at cycle N+1 and mem_req is never asserted.
- A start arriving in the same cycle as done is ignored. start is accepted only in IDLE.

## Test plan
- K=3, C=1, base=0x0010, row_stride=8, rdata=addr, gnt=1, latency 1:
  - addresses 0x10,0x11,0x12,0x18,…,0x22 in order
  - out_data words 0..2,5..7,10..12 = those addresses; all other words 0
  - done at cycle 11.
- K=2, C=3, plane_stride=0x100, row_stride=4, base=0:
  - 12 requests; the 5th request address = 0x100
  - word 25 (c=1,r=0,col=0) = rdata of the 5th response.
- MAX_OUTST=4, memory latency 6 with random gnt stalls:
  - mem_addr holds while ungranted
  - never more than 4 reads in flight
  - out_data is correct.
- size=0, size=6, and channels=5 (each separately): err and done pulse together at N+1, mem_req stays 0, out_data = 0.
- base=0xFFFE, K=2, row_stride=1: addresses 0xFFFE,0xFFFF,0xFFFF,0x0000 (wrap-around).
- reset asserted in mid-REQ with 3 reads outstanding: all outputs return to reset values at once. A following valid start completes correctly.
